// File: rtl/alu_pkg.sv
// Shared types for the ALU result queue.
//   STAT_W            status word width (Z=0, N=1, C=2, V=3)
//   ALU_DATA_W        result / upper word width used by the queue entry
//   phase_e           output beat phase of the head entry (LO, HI)
//   entry_t           one queued ALU result
package alu_pkg;

  localparam int unsigned ALU_DATA_W = 32;
  localparam int unsigned STAT_W     = 4;

  localparam int unsigned STAT_Z = 0;
  localparam int unsigned STAT_N = 1;
  localparam int unsigned STAT_C = 2;
  localparam int unsigned STAT_V = 3;

  typedef enum logic {
    PH_LO = 1'b0,
    PH_HI = 1'b1
  } phase_e;

  typedef struct packed {
    logic [ALU_DATA_W-1:0] result;
    logic [ALU_DATA_W-1:0] upper;
    logic                  has_upper;
    logic [STAT_W-1:0]     status;
  } entry_t;

endpackage

// File: rtl/alu_sync_fifo.sv
// Synchronous FIFO of Depth words with registered storage.
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   push_i, wdata_i    write request and data (ignored when full)
//   pop_i              read request (ignored when empty)
//   rdata_o            head word
//   count_o            occupied entries
//   full_o, empty_o    occupancy flags
// Depth must be a power of two so the pointers wrap naturally.
module alu_sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic [CntW-1:0]  count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the consumer only looks at it while count is non-zero.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/alu_result_queue.sv
// ALU result queue: buffers result/status/upper words and emits each entry as one beat
// (LO only) or two beats (LO then HI) over a valid/ready interface.
//   clk, rst_n                      clock, asynchronous active-low reset
//   in_valid/in_ready               ALU-side handshake; in_ready = not full
//   in_result, in_upper,
//   in_has_upper, in_status         entry contents
//   out_valid/out_ready             consumer-side handshake, one beat per transfer
//   out_data, out_status, out_last  head entry beat; zero while empty
//   count                           occupied entries
//   clear_sticky, sticky_status     accumulated status flags
// Build option: define ALU_RESQ_STICKY_EN to implement the sticky status register;
// otherwise sticky_status is tied to zero and clear_sticky is ignored.
// DATA_W and STAT_W must match the widths of alu_pkg::entry_t.
module alu_result_queue
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = alu_pkg::ALU_DATA_W,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned STAT_W = alu_pkg::STAT_W,
  localparam int unsigned CntW  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic [DATA_W-1:0] in_upper,
  input  logic              in_has_upper,
  input  logic [STAT_W-1:0] in_status,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [STAT_W-1:0] out_status,
  output logic              out_last,
  output logic [CntW-1:0]   count,
  input  logic              clear_sticky,
  output logic [STAT_W-1:0] sticky_status
);

  entry_t wr_entry, head;
  phase_e phase_q, phase_d;
  logic   push, beat, pop;
  logic   fifo_full, fifo_empty;

  always_comb begin
    wr_entry           = '0;
    wr_entry.result    = in_result;
    wr_entry.upper     = in_upper;
    wr_entry.has_upper = in_has_upper;
    wr_entry.status    = in_status;
  end

  assign in_ready  = ~fifo_full;
  assign out_valid = ~fifo_empty;
  assign push      = in_valid & in_ready;
  assign beat      = out_valid & out_ready;
  // The entry leaves only on its final beat.
  assign pop       = beat & (~head.has_upper | (phase_q == PH_HI));

  alu_sync_fifo #(
    .Width ($bits(entry_t)),
    .Depth (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (push),
    .wdata_i (wr_entry),
    .pop_i   (pop),
    .rdata_o (head),
    .count_o (count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    phase_d = phase_q;
    unique case (phase_q)
      PH_LO:   if (beat && head.has_upper) phase_d = PH_HI;
      PH_HI:   if (beat) phase_d = PH_LO;
      default: phase_d = PH_LO;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= PH_LO;
    end else begin
      phase_q <= phase_d;
    end
  end

  // Outputs are forced to zero while empty so stale storage never shows.
  always_comb begin
    out_data   = '0;
    out_status = '0;
    out_last   = 1'b0;
    if (out_valid) begin
      out_data   = (phase_q == PH_HI) ? head.upper : head.result;
      out_status = head.status;
      out_last   = ~head.has_upper | (phase_q == PH_HI);
    end
  end

`ifdef ALU_RESQ_STICKY_EN
  logic [STAT_W-1:0] sticky_q, sticky_d;
  logic [STAT_W-1:0] push_status;

  assign push_status = push ? in_status : '0;

  // A clear coincident with a push keeps the new status.
  always_comb begin
    sticky_d = (clear_sticky ? '0 : sticky_q) | push_status;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= '0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign sticky_status = sticky_q;
`else
  logic unused_clear_sticky;
  assign unused_clear_sticky = clear_sticky;
  assign sticky_status       = '0;
`endif

endmodule

// File: tb/tb_alu_result_queue.sv
module tb_alu_result_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_result = '0;
  logic [31:0] in_upper = '0;
  logic        in_has_upper = 1'b0;
  logic [3:0]  in_status = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [3:0]  out_status;
  logic        out_last;
  logic [2:0]  count;
  logic        clear_sticky = 1'b0;
  logic [3:0]  sticky_status;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_result_queue #(
    .DATA_W (32),
    .DEPTH  (4),
    .STAT_W (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_result     (in_result),
    .in_upper      (in_upper),
    .in_has_upper  (in_has_upper),
    .in_status     (in_status),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_status    (out_status),
    .out_last      (out_last),
    .count         (count),
    .clear_sticky  (clear_sticky),
    .sticky_status (sticky_status)
  );

  typedef struct {
    logic        iv;
    logic [31:0] res;
    logic [31:0] up;
    logic        hu;
    logic [3:0]  st;
    logic        ordy;
    logic        e_ir;
    logic        e_ov;
    logic [31:0] e_od;
    logic        e_ol;
    logic [3:0]  e_os;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic iv, input logic [31:0] res, input logic [31:0] up,
                              input logic hu, input logic [3:0] st, input logic ordy,
                              input logic e_ir, input logic e_ov, input logic [31:0] e_od,
                              input logic e_ol, input logic [3:0] e_os, input logic [2:0] e_cnt);
    vec_t v;
    v.iv = iv; v.res = res; v.up = up; v.hu = hu; v.st = st; v.ordy = ordy;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_ol = e_ol; v.e_os = e_os; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic drive(input logic iv, input logic [31:0] res, input logic [31:0] up,
                       input logic hu, input logic [3:0] st, input logic ordy);
    in_valid = iv; in_result = res; in_upper = up; in_has_upper = hu; in_status = st;
    out_ready = ordy;
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Single beat
    vecs.push_back(mk(1, 32'h5, 32'h0, 0, 4'h0, 1,   1, 0, 32'h0, 0, 4'h0, 0));
    vecs.push_back(mk(0, 32'h0, 32'h0, 0, 4'h0, 1,   1, 1, 32'h5, 1, 4'h0, 1));
    vecs.push_back(mk(0, 32'h0, 32'h0, 0, 4'h0, 0,   1, 0, 32'h0, 0, 4'h0, 0));
    // Two beats (Mult high half)
    vecs.push_back(mk(1, 32'h1, 32'hFFFF_FFFF, 1, 4'b0100, 1, 1, 0, 32'h0, 0, 4'h0, 0));
    vecs.push_back(mk(0, 32'h0, 32'h0, 0, 4'h0, 1,   1, 1, 32'h1, 0, 4'b0100, 1));
    vecs.push_back(mk(0, 32'h0, 32'h0, 0, 4'h0, 1,   1, 1, 32'hFFFF_FFFF, 1, 4'b0100, 1));
    vecs.push_back(mk(0, 32'h0, 32'h0, 0, 4'h0, 0,   1, 0, 32'h0, 0, 4'h0, 0));
    // Fill to full with backpressure; upper words must never appear
    vecs.push_back(mk(1, 32'd10, 32'hDEAD_0010, 0, 4'hA, 0, 1, 0, 32'h0, 0, 4'h0, 0));
    vecs.push_back(mk(1, 32'd11, 32'hDEAD_0011, 0, 4'hB, 0, 1, 1, 32'd10, 1, 4'hA, 1));
    vecs.push_back(mk(1, 32'd12, 32'hDEAD_0012, 0, 4'hC, 0, 1, 1, 32'd10, 1, 4'hA, 2));
    vecs.push_back(mk(1, 32'd13, 32'hDEAD_0013, 0, 4'hD, 0, 1, 1, 32'd10, 1, 4'hA, 3));
    vecs.push_back(mk(1, 32'd14, 32'hDEAD_0014, 0, 4'hE, 0, 0, 1, 32'd10, 1, 4'hA, 4));
    // Full: pop alone, 14 still held
    vecs.push_back(mk(1, 32'd14, 32'hDEAD_0014, 0, 4'hE, 1, 0, 1, 32'd10, 1, 4'hA, 4));
    // count 3: push 14 and pop 11 together
    vecs.push_back(mk(1, 32'd14, 32'hDEAD_0014, 0, 4'hE, 1, 1, 1, 32'd11, 1, 4'hB, 3));
    vecs.push_back(mk(0, 32'h0, 32'h0, 0, 4'h0, 1,   1, 1, 32'd12, 1, 4'hC, 3));
    vecs.push_back(mk(0, 32'h0, 32'h0, 0, 4'h0, 1,   1, 1, 32'd13, 1, 4'hD, 2));
    vecs.push_back(mk(0, 32'h0, 32'h0, 0, 4'h0, 1,   1, 1, 32'd14, 1, 4'hE, 1));
    vecs.push_back(mk(0, 32'h0, 32'h0, 0, 4'h0, 0,   1, 0, 32'h0, 0, 4'h0, 0));
    // Simultaneous push/pop at count 2
    vecs.push_back(mk(1, 32'h20, 32'h0, 0, 4'h1, 0,  1, 0, 32'h0, 0, 4'h0, 0));
    vecs.push_back(mk(1, 32'h21, 32'h0, 0, 4'h2, 0,  1, 1, 32'h20, 1, 4'h1, 1));
    vecs.push_back(mk(1, 32'h22, 32'h0, 0, 4'h3, 1,  1, 1, 32'h20, 1, 4'h1, 2));
    vecs.push_back(mk(0, 32'h0, 32'h0, 0, 4'h0, 1,   1, 1, 32'h21, 1, 4'h2, 2));
    vecs.push_back(mk(0, 32'h0, 32'h0, 0, 4'h0, 1,   1, 1, 32'h22, 1, 4'h3, 1));
    vecs.push_back(mk(0, 32'h0, 32'h0, 0, 4'h0, 0,   1, 0, 32'h0, 0, 4'h0, 0));
    // Two-beat entry with a stalled HI beat, followed by a single-beat entry
    vecs.push_back(mk(1, 32'h30, 32'h31, 1, 4'h5, 0, 1, 0, 32'h0, 0, 4'h0, 0));
    vecs.push_back(mk(1, 32'h40, 32'h41, 0, 4'h6, 1, 1, 1, 32'h30, 0, 4'h5, 1));
    vecs.push_back(mk(0, 32'h0, 32'h0, 0, 4'h0, 0,   1, 1, 32'h31, 1, 4'h5, 2));
    vecs.push_back(mk(0, 32'h0, 32'h0, 0, 4'h0, 0,   1, 1, 32'h31, 1, 4'h5, 2));
    vecs.push_back(mk(0, 32'h0, 32'h0, 0, 4'h0, 1,   1, 1, 32'h31, 1, 4'h5, 2));
    vecs.push_back(mk(0, 32'h0, 32'h0, 0, 4'h0, 1,   1, 1, 32'h40, 1, 4'h6, 1));
    vecs.push_back(mk(0, 32'h0, 32'h0, 0, 4'h0, 0,   1, 0, 32'h0, 0, 4'h0, 0));

    // Reset state
    #2;
    check("rst_count", count, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_sticky", sticky_status, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Async reset between edges with two entries queued
    drive(1, 32'h77, 32'h0, 0, 4'h3, 0);
    step();
    step();
    drive(0, 32'h0, 32'h0, 0, 4'h0, 0);
    check("pre_rst_count", count, 2);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_count", count, 0);
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_in_ready", in_ready, 1);
    check("async_rst_sticky", sticky_status, 0);
    #1 rst_n = 1'b1;
    step();

    // Reset while a HI beat is pending: the next entry must start on LO
    drive(1, 32'h50, 32'h51, 1, 4'h0, 0);
    step();
    drive(0, 32'h0, 32'h0, 0, 4'h0, 1);
    step();
    check("hi_pending_data", out_data, 32'h51);
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    check("hi_rst_count", count, 0);
    step();
    drive(1, 32'h60, 32'h61, 0, 4'h0, 0);
    step();
    drive(0, 32'h0, 32'h0, 0, 4'h0, 0);
    check("post_rst_lo_data", out_data, 32'h60);
    check("post_rst_lo_last", out_last, 1);
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    step();

    // Table vectors
    foreach (vecs[i]) begin
      drive(vecs[i].iv, vecs[i].res, vecs[i].up, vecs[i].hu, vecs[i].st, vecs[i].ordy);
      #1;
      check($sformatf("v%0d_in_ready", i), in_ready, vecs[i].e_ir);
      check($sformatf("v%0d_out_valid", i), out_valid, vecs[i].e_ov);
      check($sformatf("v%0d_out_data", i), out_data, vecs[i].e_od);
      check($sformatf("v%0d_out_last", i), out_last, vecs[i].e_ol);
      check($sformatf("v%0d_out_status", i), out_status, vecs[i].e_os);
      check($sformatf("v%0d_count", i), count, vecs[i].e_cnt);
      step();
    end
    drive(0, 32'h0, 32'h0, 0, 4'h0, 0);

    // Sticky status
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    step();
    drive(1, 32'h1, 32'h0, 0, 4'b0001, 1);
    step();
    drive(1, 32'h2, 32'h0, 0, 4'b1000, 1);
    step();
    drive(0, 32'h0, 32'h0, 0, 4'h0, 1);
`ifdef ALU_RESQ_STICKY_EN
    check("sticky_accum", sticky_status, 4'b1001);
`else
    check("sticky_off_accum", sticky_status, 4'b0000);
`endif
    drive(1, 32'h3, 32'h0, 0, 4'b0010, 1);
    clear_sticky = 1'b1;
    step();
    drive(0, 32'h0, 32'h0, 0, 4'h0, 1);
    clear_sticky = 1'b0;
`ifdef ALU_RESQ_STICKY_EN
    check("sticky_clear_push", sticky_status, 4'b0010);
`else
    check("sticky_off_clear", sticky_status, 4'b0000);
`endif
    step();
    step();
    check("final_count", count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
